vram_slot_arbiter: RTL and testbench

Time-slot arbiter sharing the 2 KiB tilemap VRAM between background tile fetch and the sound/main CPU bus. It slices each 8-pixel column group of the video timing generator's horizontal count into fixed phases and drives the timing generator's counter-select so the flipped V and H bytes can be latched from its shared 8-bit bus. During active display the phases alternate between tile fetch and CPU access. During blanking the CPU receives the spare bandwidth.

---
 rtl/vram_slot_arbiter_pkg.sv | 19 +
 rtl/vram_slot_arbiter_phase_decode.sv | 32 +++
 rtl/vram_slot_arbiter.sv | 125 ++++++++++++
 tb/tb_vram_slot_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_slot_arbiter_pkg.sv
// Shared types and constants for the tilemap VRAM slot arbiter.
package vram_slot_pkg;

    localparam int VRAM_AW = 11;

    localparam logic [2:0] PH_VLATCH    = 3'd0;
    localparam logic [2:0] PH_CODE      = 3'd1;
    localparam logic [2:0] PH_ATTR      = 3'd2;
    localparam logic [2:0] PH_VALID     = 3'd3;
    localparam logic [2:0] PH_CPU_FIRST = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_DONE
    } cpu_state_t;

endpackage

// File: rtl/vram_slot_arbiter_phase_decode.sv
// Combinational decode of H/V position into fetch phases and CPU slot eligibility.
// VRAM_SLOT_BLANK_BURST_EN makes every blanking phase a CPU slot.
module vram_slot_phase_decode
    import vram_slot_pkg::*;
(
    input  logic [2:0] phase,
    input  logic       h_msb,
    input  logic       v_msb,
    output logic       active,
    output logic       ph_vlatch,
    output logic       ph_code,
    output logic       ph_attr,
    output logic       ph_valid,
    output logic       cpu_slot_eligible
);

    logic cpu_phase;

    assign active    = h_msb & v_msb;
    assign ph_vlatch = active && (phase == PH_VLATCH);
    assign ph_code   = active && (phase == PH_CODE);
    assign ph_attr   = active && (phase == PH_ATTR);
    assign ph_valid  = active && (phase == PH_VALID);
    assign cpu_phase = (phase >= PH_CPU_FIRST);

`ifdef VRAM_SLOT_BLANK_BURST_EN
    assign cpu_slot_eligible = active ? cpu_phase : 1'b1;
`else
    assign cpu_slot_eligible = cpu_phase;
`endif

endmodule

// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing tilemap VRAM between background tile fetch and the CPU.
// Optional VRAM_SLOT_BLANK_BURST_EN opens all blanking phases to the CPU.
module vram_slot_arbiter
    import vram_slot_pkg::*;
(
    input  logic               i_EMU_MCLK,
    input  logic               i_EMU_RST,
    input  logic               i_EMU_CLK6MPCEN_n,
    input  logic [8:0]         i_ABS_H_CNTR,
    input  logic [8:0]         i_ABS_V_CNTR,
    input  logic [7:0]         i_FLIP_HV_BUS,
    output logic               o_CNTRSEL,
    output logic [VRAM_AW-1:0] o_VRAM_ADDR,
    output logic               o_VRAM_WE,
    output logic [7:0]         o_VRAM_WDATA,
    input  logic [7:0]         i_VRAM_RDATA,
    input  logic               i_CPU_REQ,
    input  logic               i_CPU_RNW,
    input  logic [VRAM_AW-1:0] i_CPU_ADDR,
    input  logic [7:0]         i_CPU_WDATA,
    output logic               o_CPU_ACK,
    output logic [7:0]         o_CPU_RDATA,
    output logic [7:0]         o_TILE_CODE,
    output logic [7:0]         o_TILE_ATTR,
    output logic               o_TILE_VALID
);

    logic               ce;
    logic               active;
    logic               ph_vlatch;
    logic               ph_code;
    logic               ph_attr;
    logic               ph_valid;
    logic               cpu_slot_eligible;
    cpu_state_t         state;
    logic [7:0]         row;
    logic [7:0]         col;
    logic               req_rnw;
    logic [VRAM_AW-1:0] req_addr;
    logic [7:0]         req_wdata;
    logic               unused_bits;

    assign ce = ~i_EMU_CLK6MPCEN_n;

    // The column byte is kept for debug visibility; only its top bits feed the address.
    assign unused_bits = ^{i_ABS_H_CNTR[7:3], i_ABS_V_CNTR[7:0], col, active};

    vram_slot_phase_decode u_decode (
        .phase             (i_ABS_H_CNTR[2:0]),
        .h_msb             (i_ABS_H_CNTR[8]),
        .v_msb             (i_ABS_V_CNTR[8]),
        .active            (active),
        .ph_vlatch         (ph_vlatch),
        .ph_code           (ph_code),
        .ph_attr           (ph_attr),
        .ph_valid          (ph_valid),
        .cpu_slot_eligible (cpu_slot_eligible)
    );

    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_RST) begin
            state        <= S_IDLE;
            row          <= '0;
            col          <= '0;
            req_rnw      <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            o_CNTRSEL    <= 1'b0;
            o_VRAM_ADDR  <= '0;
            o_VRAM_WE    <= 1'b0;
            o_VRAM_WDATA <= '0;
            o_CPU_ACK    <= 1'b0;
            o_CPU_RDATA  <= '0;
            o_TILE_CODE  <= '0;
            o_TILE_ATTR  <= '0;
            o_TILE_VALID <= 1'b0;
        end else if (ce) begin
            // Select the H byte for the period that follows the V latch.
            o_CNTRSEL    <= ph_vlatch;
            o_TILE_VALID <= ph_valid;
            o_CPU_ACK    <= 1'b0;
            o_VRAM_WE    <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (i_CPU_REQ) begin
                        req_rnw   <= i_CPU_RNW;
                        req_addr  <= i_CPU_ADDR;
                        req_wdata <= i_CPU_WDATA;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!i_CPU_REQ) begin
                        state <= S_IDLE;
                    end else if (cpu_slot_eligible) begin
                        o_VRAM_ADDR  <= req_addr;
                        o_VRAM_WE    <= !req_rnw;
                        o_VRAM_WDATA <= req_wdata;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (req_rnw) o_CPU_RDATA <= i_VRAM_RDATA;
                    o_CPU_ACK <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
            endcase

            // Tile fetch never coincides with a CPU grant; it is placed last so it wins regardless.
            if (ph_vlatch) row <= i_FLIP_HV_BUS;
            if (ph_code) begin
                col         <= i_FLIP_HV_BUS;
                o_VRAM_ADDR <= {row[7:3], i_FLIP_HV_BUS[7:3], 1'b0};
            end
            if (ph_attr) begin
                o_TILE_CODE <= i_VRAM_RDATA;
                o_VRAM_ADDR <= {o_VRAM_ADDR[VRAM_AW-1:1], 1'b1};
            end
            if (ph_valid) o_TILE_ATTR <= i_VRAM_RDATA;
        end
    end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Randomized scoreboard bench for vram_slot_arbiter against a slot-rule reference model.
module tb_vram_slot_arbiter;

    typedef struct {
        int idx;
        int a;
        int b;
    } exp_t;

    localparam int NEDGES = 384 * 22;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_n = 1'b1;
    logic [8:0]  h_cnt = 9'h080;
    logic [8:0]  v_cnt = 9'h0FD;
    logic        flip = 1'b0;
    logic [7:0]  hv_bus;
    logic        cntrsel;
    logic [10:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata = 8'h00;
    logic        cpu_req = 1'b0;
    logic        cpu_rnw = 1'b1;
    logic [10:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [7:0]  tile_code;
    logic [7:0]  tile_attr;
    logic        tile_valid;

    logic [7:0]  mem [0:2047];
    logic [7:0]  mem_m [0:2047];

    exp_t tile_q[$];
    exp_t ack_q[$];
    exp_t we_q[$];

    int checks = 0;
    int passed = 0;
    int mon_k = 0;

    always #5 clk = ~clk;

    assign hv_bus = flip ? ~(cntrsel ? h_cnt[7:0] : v_cnt[7:0])
                         :  (cntrsel ? h_cnt[7:0] : v_cnt[7:0]);

    vram_slot_arbiter dut (
        .i_EMU_MCLK        (clk),
        .i_EMU_RST         (rst),
        .i_EMU_CLK6MPCEN_n (ce_n),
        .i_ABS_H_CNTR      (h_cnt),
        .i_ABS_V_CNTR      (v_cnt),
        .i_FLIP_HV_BUS     (hv_bus),
        .o_CNTRSEL         (cntrsel),
        .o_VRAM_ADDR       (vram_addr),
        .o_VRAM_WE         (vram_we),
        .o_VRAM_WDATA      (vram_wdata),
        .i_VRAM_RDATA      (vram_rdata),
        .i_CPU_REQ         (cpu_req),
        .i_CPU_RNW         (cpu_rnw),
        .i_CPU_ADDR        (cpu_addr),
        .i_CPU_WDATA       (cpu_wdata),
        .o_CPU_ACK         (cpu_ack),
        .o_CPU_RDATA       (cpu_rdata),
        .o_TILE_CODE       (tile_code),
        .o_TILE_ATTR       (tile_attr),
        .o_TILE_VALID      (tile_valid)
    );

    // VRAM clocked on the master clock: read data follows the address by one clock.
    always @(posedge clk) begin
        if (!ce_n && vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] fb(input logic [7:0] x);
        return flip ? ~x : x;
    endfunction

    function automatic bit elig(input logic [8:0] h, input logic [8:0] v);
        bit act;
        act = h[8] & v[8];
`ifdef VRAM_SLOT_BLANK_BURST_EN
        if (!act) return 1'b1;
`endif
        return h[2:0] >= 3'd4;
    endfunction

    task automatic check_reset_outputs();
        check("rst_cntrsel", int'(cntrsel), 0);
        check("rst_addr", int'(vram_addr), 0);
        check("rst_we", int'(vram_we), 0);
        check("rst_wdata", int'(vram_wdata), 0);
        check("rst_ack", int'(cpu_ack), 0);
        check("rst_cpu_rdata", int'(cpu_rdata), 0);
        check("rst_code", int'(tile_code), 0);
        check("rst_attr", int'(tile_attr), 0);
        check("rst_tile_valid", int'(tile_valid), 0);
    endtask

    task automatic pulse_ce();
        ce_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ce_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe after a CE edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            if (!ce_n) begin
                #2;
                if (tile_valid) begin
                    if (tile_q.size() == 0) check("tile_spurious", int'(tile_valid), 0);
                    else begin
                        e = tile_q.pop_front();
                        check("tile_edge", mon_k, e.idx);
                        check("tile_code", int'(tile_code), e.a);
                        check("tile_attr", int'(tile_attr), e.b);
                    end
                end
                if (vram_we) begin
                    if (we_q.size() == 0) check("we_spurious", int'(vram_we), 0);
                    else begin
                        e = we_q.pop_front();
                        check("we_edge", mon_k, e.idx);
                        check("we_addr", int'(vram_addr), e.a);
                        check("we_data", int'(vram_wdata), e.b);
                    end
                end
                if (cpu_ack) begin
                    if (ack_q.size() == 0) check("ack_spurious", int'(cpu_ack), 0);
                    else begin
                        e = ack_q.pop_front();
                        check("ack_edge", mon_k, e.idx);
                        if (e.b != 0) check("cpu_rdata", int'(cpu_rdata), e.a);
                    end
                end
                mon_k++;
            end
        end
    end

    initial begin : stimulus
        exp_t        x;
        int          mode;
        int          busy;
        bit          rst_plan;
        bit          c_rnw;
        logic [10:0] c_addr;
        logic [7:0]  c_wd;
        logic [7:0]  row_m;
        logic [7:0]  hb;
        logic [10:0] taddr;
        logic [7:0]  code_m;

        for (int i = 0; i < 2048; i++) begin
            mem_m[i] = 8'($urandom);
            mem[i] <= mem_m[i];
        end
        mode = 0; busy = 0; rst_plan = 1'b1;
        c_rnw = 1'b1; c_addr = '0; c_wd = '0;
        row_m = '0; taddr = '0; code_m = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();

        for (int e = 0; e < NEDGES; e++) begin
            if (mode == 4) begin
                // Reset lands while the read sits in ISSUE: its ACK must never appear.
                cpu_req = 1'b0;
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                check_reset_outputs();
                row_m = '0;
                mode = 0;
                rst_plan = 1'b0;
            end

            if (h_cnt[8] & v_cnt[8]) begin
                case (h_cnt[2:0])
                    3'd0: row_m = fb(v_cnt[7:0]);
                    3'd1: begin
                        hb = fb(h_cnt[7:0]);
                        taddr = {row_m[7:3], hb[7:3], 1'b0};
                    end
                    3'd2: code_m = mem_m[taddr];
                    3'd3: begin
                        x.idx = e; x.a = int'(code_m); x.b = int'(mem_m[taddr | 11'd1]);
                        tile_q.push_back(x);
                    end
                    default: ;
                endcase
            end

            case (mode)
                0: begin
                    if (rst_plan || (e < NEDGES - 40 && $urandom_range(0, 3) == 0)) begin
                        c_rnw = rst_plan ? 1'b1 : 1'($urandom_range(0, 1));
                        c_addr = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 7))
                                                             : 11'($urandom);
                        if ($urandom_range(0, 15) == 0) c_addr = 11'h7FF;
                        c_wd = 8'($urandom);
                        cpu_req = 1'b1;
                        cpu_rnw = c_rnw;
                        cpu_addr = c_addr;
                        cpu_wdata = c_wd;
                        mode = (!rst_plan && $urandom_range(0, 5) == 0) ? 3 : 1;
                    end else begin
                        cpu_req = 1'b0;
                        cpu_rnw = 1'($urandom_range(0, 1));
                        cpu_addr = 11'($urandom);
                        cpu_wdata = 8'($urandom);
                    end
                end
                1: begin
                    cpu_req = 1'b1;
                    cpu_rnw = 1'($urandom_range(0, 1));
                    cpu_addr = 11'($urandom);
                    cpu_wdata = 8'($urandom);
                    if (elig(h_cnt, v_cnt)) begin
                        x.idx = e + 1; x.b = int'(c_rnw); x.a = int'(mem_m[c_addr]);
                        if (!c_rnw) begin
                            mem_m[c_addr] = c_wd;
                            we_q.push_back('{idx: e, a: int'(c_addr), b: int'(c_wd)});
                        end
                        if (!rst_plan) ack_q.push_back(x);
                        mode = rst_plan ? 4 : 2;
                        busy = 2;
                    end
                end
                2: begin
                    // REQ is ignored in ISSUE/DONE; toggle it to prove that.
                    cpu_req = 1'($urandom_range(0, 1));
                    busy--;
                    if (busy == 0) mode = 0;
                end
                3: begin
                    cpu_req = 1'b0;
                    mode = 0;
                end
                default: ;
            endcase

            pulse_ce();

            if (h_cnt == 9'h1FF) begin
                h_cnt = 9'h080;
                v_cnt = (v_cnt == 9'h1FF) ? 9'h0F8 : v_cnt + 9'd1;
                flip = 1'($urandom_range(0, 1));
            end else begin
                h_cnt = h_cnt + 9'd1;
            end
        end

        cpu_req = 1'b0;
        repeat (4) @(negedge clk);
        check("tile_q_drained", tile_q.size(), 0);
        check("ack_q_drained", ack_q.size(), 0);
        check("we_q_drained", we_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
